// File: rtl/piso_skid_if.sv
// rtl/piso_skid_if.sv - wide-word input and serial slice output handshake bundle
//
// Purpose: carries both sides of the parallel-in / serial-out converter.
//   Input side : in_valid, data_in[DATA_IN_WIDTH], in_ready
//   Output side: data_out[DATA_OUT_WIDTH], out_valid, out_ready, out_last
// Modports:
//   slave  - the converter (consumes words, produces slices)
//   master - the environment (offers words, consumes slices)

interface piso_skid_if #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
);
    logic                      in_valid;
    logic [DATA_IN_WIDTH-1:0]  data_in;
    logic                      in_ready;
    logic [DATA_OUT_WIDTH-1:0] data_out;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport slave (
        input  in_valid,
        input  data_in,
        output in_ready,
        output data_out,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport master (
        output in_valid,
        output data_in,
        input  in_ready,
        input  data_out,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/piso_skid.sv
// rtl/piso_skid.sv - parallel-in serial-out converter with one-word skid buffer
//
// Purpose: accepts DATA_IN_WIDTH-bit words and emits them as DATA_OUT_WIDTH-bit
// slices, least significant slice first. One extra word can be parked while the
// active word is still shifting, so a continuous input stream produces one slice
// per cycle without idle cycles between words.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - piso_skid_if.slave (in_valid/data_in/in_ready,
//           data_out/out_valid/out_ready/out_last)

module piso_skid #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    piso_skid_if.slave  bus
);
    localparam int NUM_SLICES = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CNT_W      = $clog2(NUM_SLICES) + 1;

    localparam logic [1:0] ST_EMPTY      = 2'd0;
    localparam logic [1:0] ST_SHIFT      = 2'd1;
    localparam logic [1:0] ST_SHIFT_PEND = 2'd2;

    logic [1:0]               state_q;
    logic [DATA_IN_WIDTH-1:0] shift_q;
    logic [DATA_IN_WIDTH-1:0] pend_q;
    logic                     pend_valid_q;
    logic [CNT_W-1:0]         cnt_q;

    logic in_hs;
    logic out_hs;
    logic is_last;
    logic last_hs;

    // Handshake outputs depend on registered state only; out_ready never
    // reaches in_ready combinationally.
    assign bus.in_ready  = (state_q != ST_SHIFT_PEND);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.data_out  = shift_q[DATA_OUT_WIDTH-1:0];

    assign is_last      = (cnt_q == CNT_W'(NUM_SLICES - 1));
    assign bus.out_last = bus.out_valid & is_last;

    assign in_hs   = bus.in_valid  & bus.in_ready;
    assign out_hs  = bus.out_valid & bus.out_ready;
    assign last_hs = out_hs & is_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_hs) begin
                        shift_q <= bus.data_in;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (last_hs) begin
                        cnt_q <= '0;
                        if (in_hs) begin
                            // New word replaces the finishing one directly: no bubble.
                            shift_q <= bus.data_in;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end else begin
                        if (out_hs) begin
                            shift_q <= shift_q >> DATA_OUT_WIDTH;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                        if (in_hs) begin
                            pend_q       <= bus.data_in;
                            pend_valid_q <= 1'b1;
                            state_q      <= ST_SHIFT_PEND;
                        end
                    end
                end

                ST_SHIFT_PEND: begin
                    if (last_hs && pend_valid_q) begin
                        shift_q      <= pend_q;
                        cnt_q        <= '0;
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_SHIFT;
                    end else if (out_hs) begin
                        shift_q <= shift_q >> DATA_OUT_WIDTH;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q      <= ST_EMPTY;
                    pend_valid_q <= 1'b0;
                    cnt_q        <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_skid.sv
// tb/tb_piso_skid.sv - self-checking bench for piso_skid

module tb_piso_skid;
    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    piso_skid_if #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) bus ();
    piso_skid_if #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) bus2 ();

    piso_skid #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    piso_skid #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a word is "outstanding" from its accept until its last
    // slice is consumed. At most two words can be outstanding.
    typedef struct {
        logic [15:0] d;
        logic        l;
    } slice_t;

    slice_t      exp_q[$];
    int          outstanding;
    int          n_acc;
    int          n_wout;
    int          acc_cycle;
    logic [15:0] log_d[$];
    logic        log_l[$];
    int          log_c[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
            chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
            chk("rst_out_last", {63'b0, bus.out_last}, 64'd0);
            chk("rst_data_out", {48'b0, bus.data_out}, 64'd0);
            exp_q.delete();
            outstanding = 0;
        end else begin
            int     pre;
            slice_t s;
            pre = outstanding;
            chk("out_valid", {63'b0, bus.out_valid}, {63'b0, pre > 0});
            chk("in_ready", {63'b0, bus.in_ready}, {63'b0, pre < 2});
            if (pre > 0 && exp_q.size() > 0) begin
                chk("data_out", {48'b0, bus.data_out}, {48'b0, exp_q[0].d});
                chk("out_last", {63'b0, bus.out_last}, {63'b0, exp_q[0].l});
            end
            if (pre > 0 && bus.out_ready && exp_q.size() > 0) begin
                s = exp_q.pop_front();
                log_d.push_back(bus.data_out);
                log_l.push_back(bus.out_last);
                log_c.push_back(cyc);
                if (s.l) begin
                    outstanding--;
                    n_wout++;
                end
            end
            if (bus.in_valid && pre < 2) begin
                for (int i = 0; i < 4; i++) begin
                    s.d = bus.data_in[16*i +: 16];
                    s.l = (i == 3);
                    exp_q.push_back(s);
                end
                outstanding++;
                n_acc++;
                acc_cycle = cyc;
            end
        end
    end

    logic [15:0] log2_d[$];
    logic        log2_l[$];
    int          log2_c[$];

    always @(negedge clk) begin
        if (!reset && bus2.out_valid && bus2.out_ready) begin
            log2_d.push_back(bus2.data_out);
            log2_l.push_back(bus2.out_last);
            log2_c.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
        log_c.delete();
    endtask

    // Holds in_valid with word w until accepted; leaves in_valid high.
    task automatic push_word(input logic [63:0] w);
        logic acc;
        int   n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.data_in  = w;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (outstanding != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (outstanding != 0) chk("drain_timeout", 64'(outstanding), 64'd0);
    endtask

    task automatic check_slices(input string name, input int base, input logic [63:0] w);
        for (int i = 0; i < 4; i++) begin
            chk(name, {48'b0, log_d[base+i]}, {48'b0, w[16*i +: 16]});
            chk("last_flag", {63'b0, log_l[base+i]}, {63'b0, i == 3});
        end
    endtask

    initial begin
        logic [63:0] wa, wb, wc, wd;
        int          a0, a_last, acc_c, acc_start, wout_start, n;
        logic        took;

        total = 0; bad = 0; cyc = 0;
        outstanding = 0; n_acc = 0; n_wout = 0; acc_cycle = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.data_in = '0; bus2.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single word, literal slice expectations
        bus.out_ready = 1'b1;
        clear_log();
        push_word(64'h4444_3333_2222_1111);
        a0 = acc_cycle;
        bus.in_valid = 1'b0;
        wait_drain();
        chk("single_count", 64'(log_d.size()), 64'd4);
        if (log_d.size() == 4) begin
            chk("s0", {48'b0, log_d[0]}, 64'h1111);
            chk("s1", {48'b0, log_d[1]}, 64'h2222);
            chk("s2", {48'b0, log_d[2]}, 64'h3333);
            chk("s3", {48'b0, log_d[3]}, 64'h4444);
            chk("s0_last", {63'b0, log_l[0]}, 64'd0);
            chk("s3_last", {63'b0, log_l[3]}, 64'd1);
            chk("latency", 64'(log_c[0]), 64'(a0 + 1));
            chk("consecutive", 64'(log_c[3]), 64'(a0 + 4));
        end
        @(negedge clk);
        chk("empty_after", {63'b0, bus.out_valid}, 64'd0);
        @(posedge clk); #1;

        // Back-to-back A,B,C with everything held high
        wa = {$urandom, $urandom}; wb = {$urandom, $urandom}; wc = {$urandom, $urandom};
        clear_log();
        push_word(wa); push_word(wb); push_word(wc);
        bus.in_valid = 1'b0;
        wait_drain();
        chk("b2b_count", 64'(log_d.size()), 64'd12);
        if (log_d.size() == 12) begin
            check_slices("b2b_a", 0, wa);
            check_slices("b2b_b", 4, wb);
            check_slices("b2b_c", 8, wc);
            chk("b2b_nogap", 64'(log_c[11] - log_c[0]), 64'd11);
        end

        // Stall: A active, B pending, C held off
        wa = {$urandom, $urandom}; wb = {$urandom, $urandom}; wc = {$urandom, $urandom};
        bus.out_ready = 1'b0;
        clear_log();
        push_word(wa); push_word(wb);
        bus.data_in = wc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("c_held", {63'b0, bus.in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        push_word(wc);
        acc_c = acc_cycle;
        bus.in_valid = 1'b0;
        wait_drain();
        chk("stall_count", 64'(log_d.size()), 64'd12);
        if (log_d.size() == 12) begin
            check_slices("stall_a", 0, wa);
            check_slices("stall_b", 4, wb);
            check_slices("stall_c", 8, wc);
            a_last = log_c[3];
            chk("c_after_a_last", {63'b0, acc_c > a_last}, 64'd1);
        end

        // Reset during slice 2 of A with B pending
        wa = {$urandom, $urandom}; wb = {$urandom, $urandom};
        wd = 64'hDDDD_CCCC_BBBB_AAAA;
        bus.out_ready = 1'b0;
        push_word(wa); push_word(wb);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        clear_log();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_word(wd);
        bus.in_valid = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_count", 64'(log_d.size()), 64'd4);
        if (log_d.size() == 4) check_slices("post_rst_d", 0, wd);

        // Random in_valid / out_ready, 1000 words
        acc_start = n_acc;
        wout_start = n_wout;
        n = 0;
        bus.in_valid = 1'b0;
        while (n_acc - acc_start < 1000 && n < 60000) begin
            bus.out_ready = $urandom_range(0, 1) == 1;
            if (!bus.in_valid && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b1;
                bus.data_in  = {$urandom, $urandom};
            end
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) bus.in_valid = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("rand_accepted", 64'(n_acc - acc_start), 64'd1000);
        bus.out_ready = 1'b1;
        wait_drain();
        chk("rand_words_out", 64'(n_wout - wout_start), 64'd1000);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        // 16/16 instance: every slice is last, no bubble
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.data_in   = 16'h00AA;
        @(negedge clk);
        chk("w16_in_ready0", {63'b0, bus2.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus2.data_in = 16'h00BB;
        @(negedge clk);
        chk("w16_in_ready1", {63'b0, bus2.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("w16_count", 64'(log2_d.size()), 64'd2);
        if (log2_d.size() == 2) begin
            chk("w16_s0", {48'b0, log2_d[0]}, 64'h00AA);
            chk("w16_s1", {48'b0, log2_d[1]}, 64'h00BB);
            chk("w16_l0", {63'b0, log2_l[0]}, 64'd1);
            chk("w16_l1", {63'b0, log2_l[1]}, 64'd1);
            chk("w16_nogap", 64'(log2_c[1] - log2_c[0]), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_skid.md
PISO_SKID -- requirements
Module: piso_skid

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 64, the wide input word width in bits.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 16, the serial output slice width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  wide word on data_in is offered.
REQ-006 SHALL have port data_in  input  DATA_IN_WIDTH  wide word to serialise.
REQ-007 SHALL have port in_ready  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port data_out  output  DATA_OUT_WIDTH  current output slice.
REQ-009 SHALL have port out_valid  output  1  data_out is valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes data_out this cycle.
REQ-011 SHALL have port out_last  output  1  data_out is the final slice of its word.

Function
REQ-012 SHALL define NUM_SLICES = DATA_IN_WIDTH / DATA_OUT_WIDTH; DATA_IN_WIDTH not an integer multiple of DATA_OUT_WIDTH, or NUM_SLICES < 1, is unsupported configuration.
REQ-013 SHALL hold an active shift register (DATA_IN_WIDTH), a slice counter (clog2(NUM_SLICES)+1 bits), and one pending word register with its own valid flag.
REQ-014 SHALL operate a 3-state FSM: EMPTY (nothing held), SHIFT (active word only), SHIFT_PEND (active plus pending word).
REQ-015 SHALL drive in_ready = 1 in EMPTY and SHIFT, 0 in SHIFT_PEND, from registered state only (no combinational path from out_ready).
REQ-016 SHALL drive out_valid = 1 in SHIFT and SHIFT_PEND, 0 in EMPTY.
REQ-017 SHALL drive data_out = shift register bits [DATA_OUT_WIDTH-1:0]; slices leave LSB-first, so a word assembled LSB-first by an upstream serial-to-parallel stage reproduces its original slice order.
REQ-018 SHALL drive out_last = out_valid AND (slice counter == NUM_SLICES-1).
REQ-019 Input handshake = in_valid AND in_ready; output handshake = out_valid AND out_ready.
REQ-020 EMPTY + input handshake: load data_in into shift register, counter 0, go SHIFT; first slice valid the next cycle (latency 1).
REQ-021 Output handshake on a non-last slice: shift register shifts right by DATA_OUT_WIDTH (zero-fill at top), counter increments, state unchanged.
REQ-022 SHIFT, input handshake, no last-slice handshake: data_in goes to pending register, go SHIFT_PEND.
REQ-023 SHIFT, input handshake and last-slice handshake in the same cycle: data_in loads directly into shift register, counter 0, stay SHIFT (no bubble).
REQ-024 SHIFT, last-slice handshake, no input handshake: go EMPTY, counter 0.
REQ-025 SHIFT_PEND, last-slice handshake: pending word loads into shift register, counter 0, pending flag cleared, go SHIFT.
REQ-026 With in_valid and out_ready held high, SHALL sustain one slice per cycle with no idle cycle between words.
REQ-027 out_valid low with out_ready high SHALL change no state; out_ready low SHALL hold data_out, out_last and the counter stable.
REQ-028 NUM_SLICES = 1: every output handshake is a last-slice handshake and REQ-023/024/025 apply every word.
REQ-029 No word SHALL be dropped or duplicated under any combination of in_valid/out_ready.

Reset
REQ-030 While reset high SHALL force state EMPTY, counter 0, pending flag 0, shift and pending registers 0; outputs in_ready=1, out_valid=0, out_last=0, data_out=0.
REQ-031 Reset asserted mid-word SHALL discard active and pending words immediately (asynchronously), with no further slice emitted after deassertion.

Verification
REQ-032 Single word 0x4444_3333_2222_1111, out_ready=1 -> slices 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles starting 1 cycle after accept; out_last only on 0x4444; then EMPTY.
REQ-033 Back-to-back words A,B,C with in_valid and out_ready always 1 -> 12 consecutive valid slices, out_last on cycles 4/8/12, no gap.
REQ-034 out_ready=0 after word A accepted, then offer B and C -> B accepted into pending, in_ready drops to 0, C held off until A's last slice consumed; order A,B,C preserved.
REQ-035 Random out_ready (50%) and in_valid (50%), 1000 words -> output stream equals scoreboard of accepted words sliced LSB-first; no loss/duplication.
REQ-036 Assert reset during slice 2 of A with B pending -> out_valid=0 and in_ready=1 immediately; after release next accepted word D emits only D's slices.
REQ-037 DATA_IN_WIDTH=DATA_OUT_WIDTH=16, words 0x00AA,0x00BB streamed -> each slice has out_last=1, one per cycle, no bubble.
